// File: rtl/req_priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared sizing and types for the request priority encoder.
//   N_REQ     : number of request lines
//   W_IDX     : width of an encoded request index
//   req_vec_t : one bit per request line
//   idx_t     : binary request index
//   cnt_t     : population count of a req_vec_t (0..N_REQ)
// Helpers:
//   dec_onehot : W-to-N decoder, index -> one-hot vector
//   popcount   : number of set bits in a request vector
// ---------------------------------------------------------------------------
package enc_pkg;

    localparam int N_REQ = 8;
    localparam int W_IDX = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [W_IDX-1:0] idx_t;
    typedef logic [W_IDX:0]   cnt_t;

    function automatic req_vec_t dec_onehot(input idx_t i);
        req_vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic cnt_t popcount(input req_vec_t v);
        cnt_t c;
        c = '0;
        for (int b = 0; b < N_REQ; b++) begin
            c = c + cnt_t'(v[b]);
        end
        return c;
    endfunction

endpackage

// File: rtl/req_priority_encoder_if.sv
// ---------------------------------------------------------------------------
// req_priority_encoder_if
// Request/handshake bundle between a requester/consumer and the encoder.
//   en       : capture enable (requester -> encoder)
//   req      : request lines (requester -> encoder)
//   ack      : consumer accepts presented idx (consumer -> encoder)
//   valid    : idx holds an un-acknowledged pending request
//   idx      : binary index of the presented request
//   pending  : sticky pending set (status)
//   pend_cnt : population count of pending (status)
// Modports:
//   master : the side that drives en/req/ack and observes the outputs
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface req_priority_encoder_if;
    import enc_pkg::*;

    logic     en;
    req_vec_t req;
    logic     ack;
    logic     valid;
    idx_t     idx;
    req_vec_t pending;
    cnt_t     pend_cnt;

    modport master (
        output en, req, ack,
        input  valid, idx, pending, pend_cnt
    );

    modport slave (
        input  en, req, ack,
        output valid, idx, pending, pend_cnt
    );

endinterface

// File: rtl/req_priority_encoder_prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc
// Combinational priority encoder, lowest set bit wins.
//   vec_i : candidate request vector
//   sel_o : index of the lowest set bit (0 when none set)
//   any_o : 1 when at least one bit of vec_i is set
// ---------------------------------------------------------------------------
module prio_enc
    import enc_pkg::*;
(
    input  req_vec_t vec_i,
    output idx_t     sel_o,
    output logic     any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        for (int b = N_REQ - 1; b >= 0; b--) begin
            if (vec_i[b]) begin
                sel_o = idx_t'(b);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_priority_encoder.sv
// ---------------------------------------------------------------------------
// req_priority_encoder
// Latches request lines into a sticky pending set and presents the index of
// the highest-priority (lowest-index) pending request on a registered
// valid/ack handshake, one request per acknowledged cycle.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of req_priority_encoder_if
//             en, req, ack            -> inputs
//             valid, idx, pending,
//             pend_cnt                -> outputs
// ---------------------------------------------------------------------------
module req_priority_encoder
    import enc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    req_priority_encoder_if.slave bus
);

    req_vec_t pending_q, pending_d;
    logic     valid_q, valid_d;
    idx_t     idx_q, idx_d;

    req_vec_t clr;
    req_vec_t excl;
    req_vec_t cand;
    idx_t     sel;
    logic     any;
    logic     load;

    // Clear the presented bit on a real handshake; new captures are ORed in
    // afterwards so a request on the acked line in the same cycle survives.
    assign clr       = (valid_q && bus.ack) ? dec_onehot(idx_q) : '0;
    assign pending_d = (pending_q & ~clr) | (bus.en ? bus.req : '0);

    // The presented index is skipped when choosing the next one, so a line
    // that re-requests on its own ack edge waits its turn instead of being
    // handed straight back. With valid low idx is stale and excludes nothing.
    assign excl = valid_q ? dec_onehot(idx_q) : '0;
    assign cand = pending_d & ~excl;

    prio_enc u_prio_enc (
        .vec_i (cand),
        .sel_o (sel),
        .any_o (any)
    );

    // Output register is free when nothing is presented or it is being taken.
    assign load = !valid_q || bus.ack;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = any;
            if (any) begin
                idx_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.pending  = pending_q;
    assign bus.valid    = valid_q;
    assign bus.idx      = idx_q;
    assign bus.pend_cnt = popcount(pending_q);

endmodule

// File: tb/tb_req_priority_encoder.sv
module tb_req_priority_encoder;
    import enc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    req_priority_encoder_if bus ();

    req_priority_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 4 && !bus.valid; k++) step();
    endtask

    task automatic test_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        bus.ack = 1'b0;
        step();
        step();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.pending !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_pre: valid=%0b pending=%h want valid=1 pending=ff", bus.valid, bus.pending);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.idx !== 3'd0 || bus.pending !== 8'h00 || bus.pend_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%0b idx=%0d pending=%h cnt=%0d want all 0",
                     bus.valid, bus.idx, bus.pending, bus.pend_cnt);
        end
        step();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held: valid=%0b pending=%h want 0/00", bus.valid, bus.pending);
        end
        bus.en  = 1'b0;
        bus.req = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_priority();
        int exp_idx[3] = '{2, 5, 7};
        int exp_cnt[3] = '{3, 2, 1};
        bus.ack = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'b1010_0100;
        step();
        bus.en  = 1'b0;
        bus.req = '0;
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.valid !== 1'b1 || bus.idx !== idx_t'(exp_idx[i]) || bus.pend_cnt !== cnt_t'(exp_cnt[i])) begin
                n_fail++;
                $display("FAIL prio_seq[%0d]: valid=%0b idx=%0d cnt=%0d want 1/%0d/%0d",
                         i, bus.valid, bus.idx, bus.pend_cnt, exp_idx[i], exp_cnt[i]);
            end
            step();
        end
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pend_cnt !== 4'd0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_drain: valid=%0b cnt=%0d pending=%h want 0/0/00", bus.valid, bus.pend_cnt, bus.pending);
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_hold();
        bus.ack = 1'b0;
        bus.en  = 1'b1;
        bus.req = 8'h40;
        step();
        bus.req = '0;
        bus.en  = 1'b0;
        wait_valid();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd6) begin
            n_fail++;
            $display("FAIL hold_start: valid=%0b idx=%0d want 1/6", bus.valid, bus.idx);
        end
        bus.en  = 1'b1;
        bus.req = 8'h02;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.valid !== 1'b1 || bus.idx !== 3'd6 || bus.pend_cnt !== 4'd2) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: valid=%0b idx=%0d cnt=%0d want 1/6/2",
                         i, bus.valid, bus.idx, bus.pend_cnt);
            end
        end
        bus.en  = 1'b0;
        bus.req = '0;
        bus.ack = 1'b1;
        step();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd1 || bus.pend_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL hold_after_ack: valid=%0b idx=%0d cnt=%0d want 1/1/1", bus.valid, bus.idx, bus.pend_cnt);
        end
        step();
        bus.ack = 1'b0;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL hold_drain: valid=%0b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_set_beats_clear();
        bus.ack = 1'b0;
        bus.en  = 1'b1;
        bus.req = 8'h08;
        step();
        bus.en  = 1'b0;
        bus.req = '0;
        wait_valid();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd3) begin
            n_fail++;
            $display("FAIL sbc_start: valid=%0b idx=%0d want 1/3", bus.valid, bus.idx);
        end
        bus.ack = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'h08;
        step();
        bus.ack = 1'b0;
        bus.en  = 1'b0;
        bus.req = '0;
        n_tests++;
        if (bus.pending !== 8'h08) begin
            n_fail++;
            $display("FAIL sbc_pending: pending=%h want 08", bus.pending);
        end
        step();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd3) begin
            n_fail++;
            $display("FAIL sbc_represent: valid=%0b idx=%0d want 1/3", bus.valid, bus.idx);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL sbc_drain: valid=%0b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_enable();
        bus.ack = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
                n_fail++;
                $display("FAIL en_gated[%0d]: valid=%0b pending=%h want 0/00", i, bus.valid, bus.pending);
            end
        end
        bus.en = 1'b1;
        step();
        bus.en  = 1'b0;
        bus.req = '0;
        wait_valid();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd0 || bus.pending !== 8'h81) begin
            n_fail++;
            $display("FAIL en_first: valid=%0b idx=%0d pending=%h want 1/0/81", bus.valid, bus.idx, bus.pending);
        end
        bus.ack = 1'b1;
        step();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd7) begin
            n_fail++;
            $display("FAIL en_second: valid=%0b idx=%0d want 1/7", bus.valid, bus.idx);
        end
        step();
        bus.ack = 1'b0;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL en_drain: valid=%0b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_spurious_ack();
        bus.ack = 1'b1;
        bus.en  = 1'b0;
        bus.req = '0;
        step();
        step();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00 || bus.idx !== 3'd7 || bus.pend_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL spur_nochange: valid=%0b pending=%h idx=%0d cnt=%0d want 0/00/7/0",
                     bus.valid, bus.pending, bus.idx, bus.pend_cnt);
        end
        bus.en  = 1'b1;
        bus.req = 8'h10;
        step();
        bus.en  = 1'b0;
        bus.req = '0;
        wait_valid();
        n_tests++;
        if (bus.valid !== 1'b1 || bus.idx !== 3'd4 || bus.pending !== 8'h10) begin
            n_fail++;
            $display("FAIL spur_present: valid=%0b idx=%0d pending=%h want 1/4/10", bus.valid, bus.idx, bus.pending);
        end
        step();
        bus.ack = 1'b0;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL spur_cleared: valid=%0b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    initial begin
        reset   = 1'b0;
        bus.en  = 1'b0;
        bus.req = '0;
        bus.ack = 1'b0;
        #3;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.idx !== 3'd0 || bus.pending !== 8'h00 || bus.pend_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL power_on_reset: valid=%0b idx=%0d pending=%h cnt=%0d want all 0",
                     bus.valid, bus.idx, bus.pending, bus.pend_cnt);
        end
        step();
        reset = 1'b1;
        step();
        test_reset();
        test_priority();
        test_hold();
        test_set_beats_clear();
        test_enable();
        test_spurious_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
